// File: rtl/pkt_to_msg_arbiter.sv
// Round-robin arbiter sharing one packet-to-message stage between N_REQ flits buffers.
// The winner's packet is captured into a holding register and offered with valid/ready.
module pkt_to_msg_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned N_BITS_REQ = 2,
  parameter int unsigned PKT_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           r_pkt_to_msg_i,
  input  logic [N_REQ*PKT_WIDTH-1:0] pkt_link_i,
  output logic [N_REQ-1:0]           g_pkt_to_msg_o,
  input  logic [N_REQ-1:0]           req_mask_i,
  output logic                       msg_valid_o,
  input  logic                       msg_ready_i,
  output logic [PKT_WIDTH-1:0]       msg_data_o,
  output logic [N_BITS_REQ-1:0]      msg_src_o,
  output logic [CNT_WIDTH-1:0]       pkt_count_o
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic                  state_q, state_d;
  logic [N_BITS_REQ-1:0] ptr_q, ptr_d;
  logic [PKT_WIDTH-1:0]  data_q, data_d;
  logic [N_BITS_REQ-1:0] src_q, src_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      grant;
  logic [N_BITS_REQ-1:0] win;
  logic                  found;
  logic                  can_accept;
  logic                  deliver;
  logic [PKT_WIDTH-1:0]  data_sel;
  int unsigned           idx;

  assign elig       = r_pkt_to_msg_i & req_mask_i;
  assign deliver    = (state_q == StFull) & msg_ready_i;
  assign can_accept = (state_q == StEmpty) | deliver;

  // Search eligible set starting at the pointer, wrapping past the top index.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr_q + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && can_accept && rst && elig[idx[N_BITS_REQ-1:0]]) begin
        found                         = 1'b1;
        win                           = idx[N_BITS_REQ-1:0];
        grant[idx[N_BITS_REQ-1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) data_sel = pkt_link_i[k*PKT_WIDTH +: PKT_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      cnt_d   = cnt_q + CNT_WIDTH'(1);
      state_d = StEmpty;
    end
    if (found) begin
      state_d = StFull;
      data_d  = data_sel;
      src_d   = win;
      ptr_d   = (win == N_BITS_REQ'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign g_pkt_to_msg_o = grant;
  assign msg_valid_o    = (state_q == StFull);
  assign msg_data_o     = data_q;
  assign msg_src_o      = src_q;
  assign pkt_count_o    = cnt_q;

endmodule

// File: tb/tb_pkt_to_msg_arbiter.sv
// Directed bench for pkt_to_msg_arbiter; a narrow counter makes the wrap reachable.
module tb_pkt_to_msg_arbiter;

  localparam int unsigned NReq  = 4;
  localparam int unsigned NBits = 2;
  localparam int unsigned PktW  = 32;
  localparam int unsigned CntW  = 4;

  logic                  clk;
  logic                  rst;
  logic [NReq-1:0]       req;
  logic [NReq*PktW-1:0]  pkt_link;
  logic [NReq-1:0]       grant;
  logic [NReq-1:0]       mask;
  logic                  valid;
  logic                  ready;
  logic [PktW-1:0]       data;
  logic [NBits-1:0]      src;
  logic [CntW-1:0]       count;

  int total;
  int bad;

  pkt_to_msg_arbiter #(
    .N_REQ      (NReq),
    .N_BITS_REQ (NBits),
    .PKT_WIDTH  (PktW),
    .CNT_WIDTH  (CntW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .r_pkt_to_msg_i (req),
    .pkt_link_i     (pkt_link),
    .g_pkt_to_msg_o (grant),
    .req_mask_i     (mask),
    .msg_valid_o    (valid),
    .msg_ready_i    (ready),
    .msg_data_o     (data),
    .msg_src_o      (src),
    .pkt_count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then settle inputs before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req   = 4'b1111;
    mask  = 4'b1111;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) pkt_link[i*PktW +: PktW] = 32'hA5A5_0000 + 32'(i) * 32'h11;

    // Reset held for two cycles with everyone requesting
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_valid", 64'(valid), 64'h0);
      check("rst_count", 64'(count), 64'h0);
    end
    check("rst_data", 64'(data), 64'h0);
    check("rst_src", 64'(src), 64'h0);
    rst = 1'b1;
    #1;
    check("first_grant", 64'(grant), 64'h1);
    req = 4'b0000;
    #1;
    check("no_req_grant", 64'(grant), 64'h0);
    step();
    check("idle_valid", 64'(valid), 64'h0);

    // Single request from buffer 2 with backpressure
    req = 4'b0100;
    #1;
    check("single_grant", 64'(grant), 64'h4);
    step();
    req = 4'b0000;
    #1;
    check("single_valid", 64'(valid), 64'h1);
    check("single_src", 64'(src), 64'h2);
    check("single_data", 64'(data), 64'hA5A5_0022);
    req = 4'b0100;
    #1;
    check("full_blocked", 64'(grant), 64'h0);
    step();
    check("hold_valid", 64'(valid), 64'h1);
    check("hold_data", 64'(data), 64'hA5A5_0022);
    req   = 4'b0000;
    ready = 1'b1;
    #1;
    check("drain_grant", 64'(grant), 64'h0);
    step();
    check("drain_count", 64'(count), 64'h1);
    check("drain_valid", 64'(valid), 64'h0);

    // Pointer is now 3: wrap priority
    req = 4'b1001;
    #1;
    check("wrap_grant3", 64'(grant), 64'h8);
    step();
    req = 4'b0001;
    #1;
    check("wrap_grant0", 64'(grant), 64'h1);
    step();
    check("wrap_src", 64'(src), 64'h0);
    check("wrap_count", 64'(count), 64'h2);
    req = 4'b0000;
    step();
    check("wrap_drain_count", 64'(count), 64'h3);

    // Round robin from pointer 1, streaming with ready high
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", 64'(grant), 64'(4'b0001 << ((k + 1) % 4)));
      step();
      check("rr_src", 64'(src), 64'((k + 1) % 4));
      check("rr_count", 64'(count), 64'(3 + k));
    end

    // Masked requester 1 never granted
    mask = 4'b1101;
    req  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mask_grant", 64'(grant), 64'h0);
      step();
    end
    check("mask_count", 64'(count), 64'h8);
    check("mask_valid", 64'(valid), 64'h0);

    // Backpressure: pointer 2, requests 0 and 1 (1 masked)
    req   = 4'b0011;
    ready = 1'b0;
    #1;
    check("bp_grant_empty", 64'(grant), 64'h1);
    step();
    check("bp_src", 64'(src), 64'h0);
    check("bp_grant_stall", 64'(grant), 64'h0);
    step();
    ready = 1'b1;
    #1;
    check("bp_grant_drain", 64'(grant), 64'h1);
    step();
    check("bp_count", 64'(count), 64'h9);
    check("bp_valid", 64'(valid), 64'h1);
    ready = 1'b0;
    #1;
    check("bp_grant_stall2", 64'(grant), 64'h0);

    // Reset mid-transfer drops the held packet and rewinds the pointer
    mask  = 4'b1111;
    req   = 4'b1111;
    ready = 1'b1;
    rst   = 1'b0;
    #1;
    check("midrst_grant", 64'(grant), 64'h0);
    step();
    check("midrst_valid", 64'(valid), 64'h0);
    check("midrst_count", 64'(count), 64'h0);
    rst = 1'b1;

    // Stream 17 cycles from pointer 0: 16 deliveries wrap the 4-bit counter
    for (int k = 0; k < 17; k++) begin
      #1;
      check("stream_grant", 64'(grant), 64'(4'b0001 << (k % 4)));
      step();
      check("stream_count", 64'(count), 64'(k % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
